// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_timeout_ctr.sv
// Slave-response watchdog: down-counter reloaded on clear, fires a 1-cycle
// pulse on the TIMEOUT_CYCLES-th consecutive stall cycle.
module wb_arb_timeout_ctr
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic stall_i,
  output logic tmo_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count: the counter holds the number of stall cycles still tolerated.
  assign tmo_o = stall_i & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tmo_o) begin
      cnt_d = RELOAD;
    end else if (stall_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone arbiter, round-robin with bus-hold grant.
// Optional slave-response timeout enabled by defining WB_RR_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, slave outputs held at 0
// GNT0  | m0 (D$/LSU) owns the slave until m0 cyc falls
// GNT1  | m1 (I$) owns the slave until m1 cyc falls
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned SW             = DW / 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,

  input  logic [AW-1:0] m0_wbd_adr_i,
  input  logic [DW-1:0] m0_wbd_dat_i,
  input  logic [SW-1:0] m0_wbd_sel_i,
  input  logic          m0_wbd_we_i,
  input  logic          m0_wbd_cyc_i,
  input  logic          m0_wbd_stb_i,
  output logic [DW-1:0] m0_wbd_dat_o,
  output logic          m0_wbd_ack_o,
  output logic          m0_wbd_err_o,

  input  logic [AW-1:0] m1_wbd_adr_i,
  input  logic [DW-1:0] m1_wbd_dat_i,
  input  logic [SW-1:0] m1_wbd_sel_i,
  input  logic          m1_wbd_we_i,
  input  logic          m1_wbd_cyc_i,
  input  logic          m1_wbd_stb_i,
  output logic [DW-1:0] m1_wbd_dat_o,
  output logic          m1_wbd_ack_o,
  output logic          m1_wbd_err_o,

  output logic [AW-1:0] s_wbd_adr_o,
  output logic [DW-1:0] s_wbd_dat_o,
  output logic [SW-1:0] s_wbd_sel_o,
  output logic          s_wbd_we_o,
  output logic          s_wbd_cyc_o,
  output logic          s_wbd_stb_o,
  input  logic [DW-1:0] s_wbd_dat_i,
  input  logic          s_wbd_ack_i,
  input  logic          s_wbd_err_i,

  output logic [1:0]    gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       sel_cyc, sel_stb;
  logic       tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_wbd_cyc_i && m1_wbd_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_wbd_cyc_i) begin
          state_d = GNT0;
        end else if (m1_wbd_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_wbd_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_wbd_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_wbd_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_wbd_cyc_i ? GNT0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_o = {state_q == GNT1, state_q == GNT0};

  // Slave side follows the registered grant, so a switch cycle still shows the old master.
  always_comb begin
    s_wbd_adr_o = '0;
    s_wbd_dat_o = '0;
    s_wbd_sel_o = '0;
    s_wbd_we_o  = 1'b0;
    sel_cyc     = 1'b0;
    sel_stb     = 1'b0;
    case (state_q)
      GNT0: begin
        s_wbd_adr_o = m0_wbd_adr_i;
        s_wbd_dat_o = m0_wbd_dat_i;
        s_wbd_sel_o = m0_wbd_sel_i;
        s_wbd_we_o  = m0_wbd_we_i;
        sel_cyc     = m0_wbd_cyc_i;
        sel_stb     = m0_wbd_stb_i;
      end
      GNT1: begin
        s_wbd_adr_o = m1_wbd_adr_i;
        s_wbd_dat_o = m1_wbd_dat_i;
        s_wbd_sel_o = m1_wbd_sel_i;
        s_wbd_we_o  = m1_wbd_we_i;
        sel_cyc     = m1_wbd_cyc_i;
        sel_stb     = m1_wbd_stb_i;
      end
      default: begin
      end
    endcase
  end

  assign s_wbd_cyc_o = sel_cyc & ~tmo;
  assign s_wbd_stb_o = sel_stb & ~tmo;

  assign m0_wbd_dat_o = s_wbd_dat_i;
  assign m1_wbd_dat_o = s_wbd_dat_i;
  assign m0_wbd_ack_o = s_wbd_ack_i & gnt_o[0] & m0_wbd_stb_i;
  assign m1_wbd_ack_o = s_wbd_ack_i & gnt_o[1] & m1_wbd_stb_i;
  assign m0_wbd_err_o = (s_wbd_err_i | tmo) & gnt_o[0] & m0_wbd_stb_i;
  assign m1_wbd_err_o = (s_wbd_err_i | tmo) & gnt_o[1] & m1_wbd_stb_i;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic tmo_stall, tmo_clr;

  assign tmo_stall = (state_q != IDLE) & sel_stb & ~s_wbd_ack_i & ~s_wbd_err_i;
  assign tmo_clr   = (state_q == IDLE) | (state_d != state_q) | s_wbd_ack_i | s_wbd_err_i;

  wb_arb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (tmo_clr),
    .stall_i(tmo_stall),
    .tmo_o  (tmo)
  );
`else
  logic [31:0] unused_tmo_cfg;

  assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo            = 1'b0;
`endif

endmodule
